// File: rtl/multicycle_control.sv
// Multi-cycle RV32I-subset controller: sequences fetch/decode/execute/memory/writeback
// over a shared ALU and a unified ready-handshaked memory, with trap and retire counter.
module multicycle_control #(
  parameter int CNT_W           = 32,
  parameter bit SUPPORT_IMM     = 1'b1,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr,
  input  logic             mem_ready,
  input  logic             zero,
  output logic             pc_write,
  output logic             ir_write,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_ctrl,
  output logic             pc_src,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_RESET   = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXEC_R  = 4'd7,
    S_EXEC_I  = 4'd8,
    S_ALUWB   = 4'd9,
    S_BRANCH  = 4'd10,
    S_TRAP    = 4'd11,
    S_ILLSKIP = 4'd12
  } state_t;

  state_t           state_q;
  state_t           dec_state_d;
  logic [CNT_W-1:0] count_q;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       is_lw, is_sw, is_r, is_i, is_br, retire;
  logic [3:0] funct_alu;
  logic       unused_instr;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  // Register and immediate fields belong to the datapath, not to sequencing.
  assign unused_instr = ^{instr[24:15], instr[11:7]};

  assign is_lw = (opcode == 7'b0000011) && (funct3 == 3'b010);
  assign is_sw = (opcode == 7'b0100011) && (funct3 == 3'b010);
  assign is_r  = (opcode == 7'b0110011) &&
                 (((funct7 == 7'b0000000) && (funct3 inside {3'b000, 3'b110, 3'b111, 3'b010})) ||
                  ((funct7 == 7'b0100000) && (funct3 == 3'b000)));
  assign is_i  = SUPPORT_IMM && (opcode == 7'b0010011) &&
                 (funct3 inside {3'b000, 3'b010, 3'b110, 3'b111});
  assign is_br = (opcode == 7'b1100011) && (funct3 inside {3'b000, 3'b001});

  always_comb begin
    if (is_lw || is_sw)  dec_state_d = S_MEMADR;
    else if (is_r)       dec_state_d = S_EXEC_R;
    else if (is_i)       dec_state_d = S_EXEC_I;
    else if (is_br)      dec_state_d = S_BRANCH;
    else if (HALT_ON_ILLEGAL) dec_state_d = S_TRAP;
    else                 dec_state_d = S_ILLSKIP;
  end

  // funct7 only selects sub for R-type; in I-type those bits are immediate.
  always_comb begin
    case (funct3)
      3'b010:  funct_alu = 4'b0111;
      3'b110:  funct_alu = 4'b0001;
      3'b111:  funct_alu = 4'b0000;
      default: funct_alu = ((opcode == 7'b0110011) && funct7[5]) ? 4'b0110 : 4'b0010;
    endcase
  end

  assign retire = (state_q == S_MEMWB) || (state_q == S_ALUWB) || (state_q == S_BRANCH) ||
                  ((state_q == S_MEMWR) && mem_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RESET;
      count_q <= '0;
    end else begin
      if (retire) count_q <= count_q + CNT_W'(1);
      case (state_q)
        S_RESET:   state_q <= S_FETCH;
        S_FETCH:   if (mem_ready) state_q <= S_DECODE;
        S_DECODE:  state_q <= dec_state_d;
        S_MEMADR:  state_q <= is_lw ? S_MEMRD : S_MEMWR;
        S_MEMRD:   if (mem_ready) state_q <= S_MEMWB;
        S_MEMWB:   state_q <= S_FETCH;
        S_MEMWR:   if (mem_ready) state_q <= S_FETCH;
        S_EXEC_R:  state_q <= S_ALUWB;
        S_EXEC_I:  state_q <= S_ALUWB;
        S_ALUWB:   state_q <= S_FETCH;
        S_BRANCH:  state_q <= S_FETCH;
        S_TRAP:    state_q <= S_TRAP;
        S_ILLSKIP: state_q <= S_FETCH;
        default:   state_q <= S_RESET;
      endcase
    end
  end

  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_ctrl   = 4'b0000;
    pc_src     = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_ctrl  = 4'b0010;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
        alu_ctrl  = 4'b0010;
      end
      S_MEMADR: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        alu_ctrl  = 4'b0010;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = 2'b01;
        alu_ctrl  = funct_alu;
      end
      S_EXEC_I: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        alu_ctrl  = funct_alu;
      end
      S_ALUWB:  reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = 2'b01;
        alu_ctrl  = 4'b0110;
        pc_src    = 1'b1;
        pc_write  = funct3[0] ? !zero : zero;
      end
      S_TRAP:    illegal = 1'b1;
      S_ILLSKIP: illegal = 1'b1;
      default: ;
    endcase
  end

  assign state       = state_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: two instances (default build; 4-bit counter, no I-type, skip on illegal).
module tb_multicycle_control;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst_n_v, mem_ready_v, zero_v;
  logic [31:0] instr_v [2];
  wire  [1:0]  pcw_v, irw_v, iord_v, mrd_v, mwr_v, m2r_v, rw_v, psrc_v, ill_v;
  wire  [1:0]  srca_v [2];
  wire  [1:0]  srcb_v [2];
  wire  [3:0]  alu_v [2];
  wire  [3:0]  st_v [2];
  wire  [31:0] cnt0;
  wire  [3:0]  cnt1;

  multicycle_control #(.CNT_W(32), .SUPPORT_IMM(1'b1), .HALT_ON_ILLEGAL(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n_v[0]), .instr(instr_v[0]), .mem_ready(mem_ready_v[0]), .zero(zero_v[0]),
    .pc_write(pcw_v[0]), .ir_write(irw_v[0]), .iord(iord_v[0]), .mem_read(mrd_v[0]),
    .mem_write(mwr_v[0]), .mem_to_reg(m2r_v[0]), .reg_write(rw_v[0]), .alu_src_a(srca_v[0]),
    .alu_src_b(srcb_v[0]), .alu_ctrl(alu_v[0]), .pc_src(psrc_v[0]), .illegal(ill_v[0]),
    .state(st_v[0]), .instr_count(cnt0));

  multicycle_control #(.CNT_W(4), .SUPPORT_IMM(1'b0), .HALT_ON_ILLEGAL(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n_v[1]), .instr(instr_v[1]), .mem_ready(mem_ready_v[1]), .zero(zero_v[1]),
    .pc_write(pcw_v[1]), .ir_write(irw_v[1]), .iord(iord_v[1]), .mem_read(mrd_v[1]),
    .mem_write(mwr_v[1]), .mem_to_reg(m2r_v[1]), .reg_write(rw_v[1]), .alu_src_a(srca_v[1]),
    .alu_src_b(srcb_v[1]), .alu_ctrl(alu_v[1]), .pc_src(psrc_v[1]), .illegal(ill_v[1]),
    .state(st_v[1]), .instr_count(cnt1));

  typedef struct packed {
    logic pcw, irw, iord, mrd, mwr, m2r, rw;
    logic [1:0] sa, sb;
    logic [3:0] alu;
    logic psrc, ill;
  } outs_t;

  typedef struct {
    logic [31:0] instr;
    logic        zero;
    logic [3:0]  st3;
    int          cycles;
    logic [3:0]  alu;
    logic        pcw;
  } vec_t;

  typedef struct {
    logic [3:0] st;
    logic       mr;
  } ent_t;

  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BR = 4, K_ILL = 5;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_cnt [2];
  vec_t        tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic ent_t mk(input logic [3:0] st, input logic mr);
    ent_t e;
    e.st = st;
    e.mr = mr;
    return e;
  endfunction

  function automatic logic [31:0] get_cnt(input int u);
    return (u == 0) ? cnt0 : {28'd0, cnt1};
  endfunction

  function automatic outs_t act_outs(input int u);
    outs_t o;
    o.pcw = pcw_v[u];   o.irw = irw_v[u];   o.iord = iord_v[u]; o.mrd = mrd_v[u];
    o.mwr = mwr_v[u];   o.m2r = m2r_v[u];   o.rw = rw_v[u];     o.sa = srca_v[u];
    o.sb = srcb_v[u];   o.alu = alu_v[u];   o.psrc = psrc_v[u]; o.ill = ill_v[u];
    return o;
  endfunction

  // Instruction class from the ISA field rules.
  function automatic int classify(input logic [31:0] ins, input bit imm_ok);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    op = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    case (op)
      7'h03: return (f3 == 3'd2) ? K_LW : K_ILL;
      7'h23: return (f3 == 3'd2) ? K_SW : K_ILL;
      7'h33: begin
        if (f7 == 7'h00 && (f3 == 3'd0 || f3 == 3'd2 || f3 == 3'd6 || f3 == 3'd7)) return K_R;
        if (f7 == 7'h20 && f3 == 3'd0) return K_R;
        return K_ILL;
      end
      7'h13: return (imm_ok && (f3 == 3'd0 || f3 == 3'd2 || f3 == 3'd6 || f3 == 3'd7)) ? K_I : K_ILL;
      7'h63: return (f3 == 3'd0 || f3 == 3'd1) ? K_BR : K_ILL;
      default: return K_ILL;
    endcase
  endfunction

  // ALU operation named by the mnemonic: add/addi, sub, slt/slti, or/ori, and/andi.
  function automatic logic [3:0] op_alu(input logic [31:0] ins);
    if (ins[6:0] == 7'h33 && ins[31:25] == 7'h20) return 4'b0110;
    case (ins[14:12])
      3'd2:    return 4'b0111;
      3'd6:    return 4'b0001;
      3'd7:    return 4'b0000;
      default: return 4'b0010;
    endcase
  endfunction

  function automatic outs_t exp_outs(input logic [3:0] s, input logic [31:0] ins,
                                     input logic mr, input logic z);
    outs_t o;
    o = '0;
    case (s)
      4'd1:  begin o.mrd = 1; o.sb = 2'b01; o.alu = 4'b0010; o.irw = mr; o.pcw = mr; end
      4'd2:  begin o.sa = 2'b10; o.sb = 2'b10; o.alu = 4'b0010; end
      4'd3:  begin o.sa = 2'b01; o.sb = 2'b10; o.alu = 4'b0010; end
      4'd4:  begin o.mrd = 1; o.iord = 1; end
      4'd5:  begin o.rw = 1; o.m2r = 1; end
      4'd6:  begin o.mwr = 1; o.iord = 1; end
      4'd7:  begin o.sa = 2'b01; o.sb = 2'b00; o.alu = op_alu(ins); end
      4'd8:  begin o.sa = 2'b01; o.sb = 2'b10; o.alu = op_alu(ins); end
      4'd9:  o.rw = 1;
      4'd10: begin o.sa = 2'b01; o.alu = 4'b0110; o.psrc = 1; o.pcw = ins[12] ? !z : z; end
      4'd11, 4'd12: o.ill = 1;
      default: ;
    endcase
    return o;
  endfunction

  task automatic step(input int u, input logic [3:0] es, input logic mr, input logic z);
    @(negedge clk);
    mem_ready_v[u] = mr;
    zero_v[u] = z;
    #1;
    chk($sformatf("u%0d state", u), 32'(st_v[u]), 32'(es));
    chk($sformatf("u%0d outputs in state %0d", u, es), 32'(act_outs(u)),
        32'(exp_outs(es, instr_v[u], mr, z)));
  endtask

  // Build the expected state walk for one instruction, then drive and check it cycle by cycle.
  task automatic run_instr(input int u, input logic [31:0] ins, input logic z,
                           input int wf, input int wm);
    ent_t q[$];
    int   k;
    k = classify(ins, u == 0);
    instr_v[u] = ins;
    repeat (wf) q.push_back(mk(4'd1, 1'b0));
    q.push_back(mk(4'd1, 1'b1));
    q.push_back(mk(4'd2, rb()));
    case (k)
      K_R:  begin q.push_back(mk(4'd7, rb())); q.push_back(mk(4'd9, rb())); end
      K_I:  begin q.push_back(mk(4'd8, rb())); q.push_back(mk(4'd9, rb())); end
      K_LW: begin
        q.push_back(mk(4'd3, rb()));
        repeat (wm) q.push_back(mk(4'd4, 1'b0));
        q.push_back(mk(4'd4, 1'b1));
        q.push_back(mk(4'd5, rb()));
      end
      K_SW: begin
        q.push_back(mk(4'd3, rb()));
        repeat (wm) q.push_back(mk(4'd6, 1'b0));
        q.push_back(mk(4'd6, 1'b1));
      end
      K_BR: q.push_back(mk(4'd10, rb()));
      default: begin
        if (u == 0) repeat (6) q.push_back(mk(4'd11, rb()));
        else        q.push_back(mk(4'd12, rb()));
      end
    endcase
    foreach (q[i]) step(u, q[i].st, q[i].mr, z);
    if (k != K_ILL) exp_cnt[u] = (u == 1) ? ((exp_cnt[u] + 1) & 32'hF) : (exp_cnt[u] + 1);
    @(posedge clk);
    #1;
    chk($sformatf("u%0d count after %h", u, ins), get_cnt(u), exp_cnt[u]);
  endtask

  task automatic do_reset(input int u);
    rst_n_v[u] = 1'b0;
    mem_ready_v[u] = 1'b1;
    zero_v[u] = 1'b0;
    instr_v[u] = 32'h0;
    @(negedge clk);
    #1;
    chk($sformatf("u%0d state in reset", u), 32'(st_v[u]), 32'd0);
    chk($sformatf("u%0d outputs in reset", u), 32'(act_outs(u)), 32'd0);
    chk($sformatf("u%0d count in reset", u), get_cnt(u), 32'd0);
    @(posedge clk);
    #1;
    rst_n_v[u] = 1'b1;
    exp_cnt[u] = 0;
    step(u, 4'd0, 1'b1, 1'b0);
    step(u, 4'd1, 1'b0, 1'b0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          n;
    logic [3:0]  st3, alu_r;
    logic        pcw_r;
    logic [31:0] ins;

    rst_n_v = 2'b00;
    mem_ready_v = 2'b11;
    zero_v = 2'b00;
    instr_v[0] = 32'h0;
    instr_v[1] = 32'h0;
    exp_cnt[0] = 0;
    exp_cnt[1] = 0;

    //         instr         zero  st3    cycles alu      pcw
    tbl[0]  = '{32'h002081B3, 1'b0, 4'd7,  4, 4'b0010, 1'b0};  // add
    tbl[1]  = '{32'h402081B3, 1'b0, 4'd7,  4, 4'b0110, 1'b0};  // sub
    tbl[2]  = '{32'h0020E1B3, 1'b0, 4'd7,  4, 4'b0001, 1'b0};  // or
    tbl[3]  = '{32'h0020F1B3, 1'b0, 4'd7,  4, 4'b0000, 1'b0};  // and
    tbl[4]  = '{32'h0020A1B3, 1'b0, 4'd7,  4, 4'b0111, 1'b0};  // slt
    tbl[5]  = '{32'h00508193, 1'b0, 4'd8,  4, 4'b0010, 1'b0};  // addi
    tbl[6]  = '{32'h0050A193, 1'b0, 4'd8,  4, 4'b0111, 1'b0};  // slti
    tbl[7]  = '{32'h0050E193, 1'b0, 4'd8,  4, 4'b0001, 1'b0};  // ori
    tbl[8]  = '{32'h0050F193, 1'b0, 4'd8,  4, 4'b0000, 1'b0};  // andi
    tbl[9]  = '{32'h0000A183, 1'b0, 4'd3,  5, 4'b0000, 1'b0};  // lw
    tbl[10] = '{32'h0030A223, 1'b0, 4'd3,  4, 4'b0000, 1'b0};  // sw
    tbl[11] = '{32'h00208463, 1'b1, 4'd10, 3, 4'b0000, 1'b1};  // beq taken
    tbl[12] = '{32'h00209463, 1'b1, 4'd10, 3, 4'b0000, 1'b0};  // bne not taken
    tbl[13] = '{32'h00208463, 1'b0, 4'd10, 3, 4'b0000, 1'b0};  // beq not taken
    tbl[14] = '{32'h00209463, 1'b0, 4'd10, 3, 4'b0000, 1'b1};  // bne taken

    do_reset(0);

    for (int i = 0; i < 15; i++) begin
      instr_v[0] = tbl[i].instr;
      zero_v[0] = tbl[i].zero;
      mem_ready_v[0] = 1'b1;
      n = 1;
      st3 = 4'd0;
      alu_r = 4'd0;
      pcw_r = 1'b0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        #1;
        if (st_v[0] == 4'd1) break;
        n++;
        if (n == 3) st3 = st_v[0];
        if (st_v[0] == 4'd7 || st_v[0] == 4'd8) alu_r = alu_v[0];
        if (st_v[0] == 4'd10) pcw_r = pcw_v[0];
      end
      chk($sformatf("vec%0d cycles", i), 32'(n), 32'(tbl[i].cycles));
      chk($sformatf("vec%0d state after decode", i), 32'(st3), 32'(tbl[i].st3));
      chk($sformatf("vec%0d alu_ctrl", i), 32'(alu_r), 32'(tbl[i].alu));
      chk($sformatf("vec%0d branch pc_write", i), 32'(pcw_r), 32'(tbl[i].pcw));
      exp_cnt[0] = exp_cnt[0] + 1;
      $display("vec%0d instr=%h cycles=%0d st3=%0d alu=%b pcw=%b", i, tbl[i].instr, n, st3, alu_r, pcw_r);
    end
    mem_ready_v[0] = 1'b0;
    chk("u0 count after table", cnt0, exp_cnt[0]);

    run_instr(0, 32'h0000A183, 1'b0, 0, 2);
    run_instr(0, 32'h0030A223, 1'b0, 1, 2);

    for (int i = 0; i < 40; i++) begin
      ins = tbl[$urandom_range(0, 14)].instr;
      ins = (ins & ~32'h01FF8F80) | ($urandom & 32'h01FF8F80);
      run_instr(0, ins, rb(), $urandom_range(0, 2), $urandom_range(0, 2));
      $display("u0 rand%0d instr=%h count=%0d", i, ins, cnt0);
    end

    run_instr(0, 32'hFFFFFFFF, 1'b0, 0, 0);
    #2;
    rst_n_v[0] = 1'b0;
    #1;
    chk("u0 state after reset from trap", 32'(st_v[0]), 32'd0);
    chk("u0 illegal after reset from trap", 32'(ill_v[0]), 32'd0);
    chk("u0 count after reset", cnt0, 32'd0);
    $display("u0 trap then reset: state=%0d illegal=%b", st_v[0], ill_v[0]);

    do_reset(1);
    for (int i = 0; i < 16; i++) run_instr(1, 32'h002081B3, 1'b0, 0, 0);
    chk("u1 count wrap after 16 ops", 32'(cnt1), 32'd0);
    $display("u1 16 adds: count=%0d", cnt1);

    run_instr(1, 32'hFFFFFFFF, 1'b0, 0, 0);
    run_instr(1, 32'h00508193, 1'b0, 0, 0);
    $display("u1 illegal skips: count=%0d", cnt1);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) ins = $urandom;
      else begin
        ins = tbl[$urandom_range(0, 14)].instr;
        ins = (ins & ~32'h01FF8F80) | ($urandom & 32'h01FF8F80);
      end
      run_instr(1, ins, rb(), $urandom_range(0, 2), $urandom_range(0, 2));
      $display("u1 rand%0d instr=%h count=%0d", i, ins, cnt1);
    end

    instr_v[1] = 32'h0030A223;
    step(1, 4'd1, 1'b1, 1'b0);
    step(1, 4'd2, 1'b1, 1'b0);
    step(1, 4'd3, 1'b1, 1'b0);
    step(1, 4'd6, 1'b0, 1'b0);
    step(1, 4'd6, 1'b0, 1'b0);
    #2;
    rst_n_v[1] = 1'b0;
    #1;
    chk("u1 mem_write after async reset", 32'(mwr_v[1]), 32'd0);
    chk("u1 state after async reset", 32'(st_v[1]), 32'd0);
    chk("u1 count after async reset", 32'(cnt1), 32'd0);
    $display("u1 reset mid-MEMWR: state=%0d mem_write=%b count=%0d", st_v[1], mwr_v[1], cnt1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
